xor_arbiter_puf: RTL and testbench
==================================

# xor_arbiter_puf

Multi-chain XOR arbiter PUF with an on-chip measurement controller. It accepts a challenge over a valid/ready handshake and launches the excitation pulse into `C_CHAINS` parallel `arbiter_puf` instances. Each challenge is evaluated `C_REPS` times, with a majority vote per chain, and the vote results are XOR-combined into one response bit. Per-chain raw bits and instability flags are also returned for characterisation. The block sits between the challenge source (host/LFSR) and the response collector.

## Interface
- `C_LENGTH`, 64: challenge bits per chain; all chains receive the same challenge.
- `C_CHAINS`, 4: number of arbiter chains XORed together; must be ≥1.
- `C_REPS`, 5: evaluations per challenge; must be odd and ≥1.
- `C_SETTLE`, 16: clock cycles per pulse phase (high and low); must be ≥3.
- `C_DFF_TYPE`, "PRIMITIVE": passed unchanged to each `arbiter_puf`.

Ports:
- `iclk`  in  1  system clock.
- `irst`  in  1  reset. The block uses one clock; reset is asynchronous and active-high.
- `ichallenge`  in  C_LENGTH  challenge, captured on accept.
- `ivalid`  in  1  challenge valid.
- `oready`  out  1  block idle and able to accept a challenge.
- `oresponse`  out  1  XOR of the per-chain majority bits.
- `oraw`  out  C_CHAINS  per-chain majority bits.
- `ounstable`  out  C_CHAINS  per-chain flag: the votes were not unanimous.
- `ovalid`  out  1  result valid.
- `iready`  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, LAUNCH, RELEASE, DONE.
- IDLE
  - `oready`=1.
  - On `ivalid`&&`oready`: register `ichallenge`, clear the rep counter, clear the per-chain ones counters, go to LAUNCH.
- LAUNCH
  - Internal pulse register driven to 1; settle counter counts `C_SETTLE` cycles.
  - On the last LAUNCH cycle, each chain's 2-FF synchronised response is added to its ones counter. Counter width is clog2(`C_REPS`+1).
  - Then go to RELEASE.
- RELEASE
  - Pulse driven to 0 for `C_SETTLE` cycles, so the arbiter DFFs re-arm.
  - At the end: if rep counter < `C_REPS`-1, increment it and go to LAUNCH; otherwise latch the results and go to DONE.
- Result latch
  - `oraw[i]` = ones[i] > `C_REPS`/2.
  - `ounstable[i]` = ones[i]≠0 && ones[i]≠`C_REPS`.
  - `oresponse` = ^`oraw`.
- DONE
  - `ovalid`=1; all outputs are held stable until `iready`.
  - On `ivalid`... no: on `ovalid`&&`iready`, go to IDLE.
- `ichallenge` and `ivalid` are ignored outside IDLE. The registered challenge is stable for the whole measurement.
- Reset, including mid-measurement:
  - FSM goes to IDLE; pulse is forced to 0 immediately.
  - All counters and synchronisers are cleared.
  - `oresponse`, `oraw`, `ounstable`, `ovalid` = 0.
  - `oready` = 0 while `irst` is high, and 1 from the first clock after release.

## Timing
- Accept edge E0: the pulse is high in the cycle after E0.
- `ovalid` rises at edge E0 + 2·`C_REPS`·`C_SETTLE`. With defaults this is E0+160.
- Synchronizer latency is 2 cycles and lies inside LAUNCH. This is why `C_SETTLE` must be ≥3.
- No back-to-back acceptance:
  - The DONE→IDLE handshake edge completes the transfer.
  - The earliest new accept is the following edge.
  - Throughput is 1 challenge per 2·`C_REPS`·`C_SETTLE`+2 cycles.
- `ovalid` held with `iready`=0: the block stays in DONE indefinitely and the outputs do not change.
- `oready` is combinational from the state (IDLE && !`irst`). All other outputs are registered.

## Structure
- Shared package/header holds:
  - FSM state encodings (2-bit);
  - the clog2 function;
  - parameter-legality checks (odd `C_REPS`, `C_SETTLE`≥3, `C_CHAINS`≥1), which stop elaboration when violated.
- Generate loop instantiates `C_CHAINS` × `arbiter_puf`, all sharing the pulse and the registered challenge.
- One sub-module `puf_sync_vote` per chain contains:
  - the 2-FF synchroniser;
  - the ones counter with clear/sample enables;
  - the majority and unanimity outputs.

## Test plan
The bench forces each chain's `oresponse` to drive the stimulus.

- Defaults, chains forced to constant 1,0,1,1 → `oraw`=4'b1101, `ounstable`=0, `oresponse`=1, `ovalid` at E0+160.
- Chain 0 forced to sequence 1,0,1,0,1 across the 5 reps, others 0 → `oraw[0]`=1, `ounstable`=4'b0001, `oresponse`=1.
- `iready` held low 50 cycles after `ovalid` → outputs stable, `oready`=0 and `ivalid` ignored; `iready` pulse → IDLE, next accept on the following edge.
- `irst` asserted at cycle 70 of a measurement → pulse 0 and all outputs 0 immediately; after release `oready`=1 and a fresh measurement gives the correct result.
- `C_REPS`=1, `C_SETTLE`=3, `C_CHAINS`=1 → `ovalid` at E0+6, `ounstable` always 0.
- Change `ichallenge` mid-measurement → result matches the challenge captured at accept.

Source files
------------

// File: rtl/xor_arbiter_puf_pkg.sv
// xor_arbiter_puf_pkg: shared FSM encoding, sizing helper and parameter legality check
package xor_arbiter_puf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Bits needed to hold values 0..v-1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Odd vote count so a majority always exists; settle must cover the 2-cycle synchroniser
    function automatic bit params_ok(input int chains, input int reps, input int settle);
        return (chains >= 1) && (reps >= 1) && (reps % 2 == 1) && (settle >= 3);
    endfunction

endpackage

// File: rtl/arbiter_puf.sv
// arbiter_puf: switch-box delay chain racing one pulse down two paths into an arbiter flop
module arbiter_puf #(
    parameter int    C_LENGTH   = 64,
    parameter string C_DFF_TYPE = "PRIMITIVE"
) (
    input  logic                ipulse,
    input  logic [C_LENGTH-1:0] ichallenge,
    output logic                oresponse
);

    logic arm_a;
    logic arm_b;

    // Each challenge bit either passes both paths straight through or crosses them
    for (genvar i = 0; i < C_LENGTH; i++) begin : g_stage
        logic a_in;
        logic b_in;
        logic a;
        logic b;
        if (i == 0) begin : g_first
            assign a_in = ipulse;
            assign b_in = ipulse;
        end else begin : g_next
            assign a_in = g_stage[i-1].a;
            assign b_in = g_stage[i-1].b;
        end
        assign a = ichallenge[i] ? a_in : b_in;
        assign b = ichallenge[i] ? b_in : a_in;
    end

    assign arm_a = g_stage[C_LENGTH-1].a;
    assign arm_b = g_stage[C_LENGTH-1].b;

    if (C_DFF_TYPE == "PRIMITIVE") begin : g_prim
        // Arbiter: path A edge samples path B; 1 means B won the race
        always_ff @(posedge arm_a) oresponse <= arm_b;
    end else begin : g_swap
        // Arbiter with roles swapped: path B edge samples path A, inverted to keep polarity
        always_ff @(posedge arm_b) oresponse <= ~arm_a;
    end

endmodule

// File: rtl/puf_sync_vote.sv
// puf_sync_vote: per-chain 2-FF synchroniser, ones counter and majority/unanimity decode
module puf_sync_vote
    import xor_arbiter_puf_pkg::*;
#(
    parameter int C_REPS = 5
) (
    input  logic iclk,
    input  logic irst,
    input  logic iresp,
    input  logic iclear,
    input  logic isample,
    output logic omajority,
    output logic ounstable
);

    localparam int OW = clog2(C_REPS + 1);

    logic [1:0]    sync;
    logic [OW-1:0] ones;

    // Resynchronise the arbiter output and count how many evaluations returned 1
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            sync <= '0;
            ones <= '0;
        end else begin
            sync <= {sync[0], iresp};
            ones <= iclear ? '0 : isample ? ones + OW'(sync[1]) : ones;
        end
    end

    assign omajority = ones > OW'(C_REPS / 2);
    assign ounstable = (ones != '0) && (ones != OW'(C_REPS));

endmodule

// File: rtl/xor_arbiter_puf.sv
// xor_arbiter_puf: measurement controller driving C_CHAINS arbiter PUFs with majority vote and XOR combine
module xor_arbiter_puf
    import xor_arbiter_puf_pkg::*;
#(
    parameter int    C_LENGTH   = 64,
    parameter int    C_CHAINS   = 4,
    parameter int    C_REPS     = 5,
    parameter int    C_SETTLE   = 16,
    parameter string C_DFF_TYPE = "PRIMITIVE"
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic [C_LENGTH-1:0] ichallenge,
    input  logic                ivalid,
    output logic                oready,
    output logic                oresponse,
    output logic [C_CHAINS-1:0] oraw,
    output logic [C_CHAINS-1:0] ounstable,
    output logic                ovalid,
    input  logic                iready
);

    localparam int SW = clog2(C_SETTLE);
    localparam int RW = clog2(C_REPS + 1);

    if (!params_ok(C_CHAINS, C_REPS, C_SETTLE)) begin : g_bad_params
        $fatal(1, "xor_arbiter_puf: need C_CHAINS>=1, odd C_REPS>=1, C_SETTLE>=3");
    end

    state_t              state;
    logic                pulse;
    logic [C_LENGTH-1:0] chal;
    logic [SW-1:0]       cnt;
    logic [RW-1:0]       rep;
    logic [C_CHAINS-1:0] chain_resp;
    logic [C_CHAINS-1:0] maj;
    logic [C_CHAINS-1:0] unstable;
    logic                last;
    logic                clear;
    logic                sample;

    assign last   = cnt == SW'(C_SETTLE - 1);
    assign oready = (state == IDLE) && !irst;
    assign clear  = (state == IDLE) && ivalid;
    assign sample = (state == LAUNCH) && last;

    for (genvar i = 0; i < C_CHAINS; i++) begin : g_chain
        arbiter_puf #(
            .C_LENGTH  (C_LENGTH),
            .C_DFF_TYPE(C_DFF_TYPE)
        ) u_puf (
            .ipulse    (pulse),
            .ichallenge(chal),
            .oresponse (chain_resp[i])
        );
        puf_sync_vote #(
            .C_REPS(C_REPS)
        ) u_vote (
            .iclk     (iclk),
            .irst     (irst),
            .iresp    (chain_resp[i]),
            .iclear   (clear),
            .isample  (sample),
            .omajority(maj[i]),
            .ounstable(unstable[i])
        );
    end

    // Measurement sequencer: pulse high/low phases per rep, then hold the voted result until taken
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state     <= IDLE;
            pulse     <= 1'b0;
            chal      <= '0;
            cnt       <= '0;
            rep       <= '0;
            oresponse <= 1'b0;
            oraw      <= '0;
            ounstable <= '0;
            ovalid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ivalid) begin
                        chal  <= ichallenge;
                        rep   <= '0;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        pulse <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last && rep != RW'(C_REPS - 1)) begin
                        rep   <= rep + 1'b1;
                        pulse <= 1'b1;
                        state <= LAUNCH;
                    end else if (last) begin
                        oraw      <= maj;
                        ounstable <= unstable;
                        oresponse <= ^maj;
                        ovalid    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (iready) begin
                        ovalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_arbiter_puf.sv
// tb_xor_arbiter_puf: directed checks of the XOR arbiter PUF controller with forced chain responses
module tb_xor_arbiter_puf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] chal = '0;
    logic        ivalid = 1'b0;
    logic        iready = 1'b0;
    logic        oready;
    logic        oresp;
    logic [3:0]  oraw;
    logic [3:0]  ounst;
    logic        ovalid;

    logic [63:0] s_chal = '0;
    logic        s_ivalid = 1'b0;
    logic        s_iready = 1'b0;
    logic        s_oready;
    logic        s_oresp;
    logic [0:0]  s_oraw;
    logic [0:0]  s_ounst;
    logic        s_ovalid;

    int nvec = 0;
    int nerr = 0;
    logic [3:0] fv;

    always #5 clk = ~clk;

    xor_arbiter_puf dut (
        .iclk(clk), .irst(rst), .ichallenge(chal), .ivalid(ivalid), .oready(oready),
        .oresponse(oresp), .oraw(oraw), .ounstable(ounst), .ovalid(ovalid), .iready(iready)
    );

    xor_arbiter_puf #(.C_LENGTH(64), .C_CHAINS(1), .C_REPS(1), .C_SETTLE(3)) dut_s (
        .iclk(clk), .irst(rst), .ichallenge(s_chal), .ivalid(s_ivalid), .oready(s_oready),
        .oresponse(s_oresp), .oraw(s_oraw), .ounstable(s_ounst), .ovalid(s_ovalid), .iready(s_iready)
    );

    task automatic accept(input logic [63:0] c);
        @(negedge clk);
        chal   = c;
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ovalid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        iready = 1'b1;
        @(posedge clk);
        #1;
        iready = 1'b0;
        nvec++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            nerr++;
            $display("FAIL handshake: ovalid=%b oready=%b, required 0 1", ovalid, oready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({oready, ovalid, oresp, oraw, ounst, dut.pulse} !== 12'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got %b, required all 0", {oready, ovalid, oresp, oraw, ounst, dut.pulse});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if (oready !== 1'b1 || s_oready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release: oready=%b s_oready=%b, required 1 1", oready, s_oready);
        end
    endtask

    task automatic test_constant();
        int n;
        fv = 4'b1101;
        force dut.chain_resp = fv;
        accept(64'h0123_4567_89ab_cdef);
        nvec++;
        if (dut.pulse !== 1'b1 || oready !== 1'b0) begin
            nerr++;
            $display("FAIL launch_pulse: pulse=%b oready=%b, required 1 0", dut.pulse, oready);
        end
        wait_valid(n);
        nvec++;
        if (n !== 160) begin
            nerr++;
            $display("FAIL const_latency: ovalid after %0d cycles, required 160", n);
        end
        nvec++;
        if (oraw !== 4'b1101 || ounst !== 4'b0000 || oresp !== 1'b1) begin
            nerr++;
            $display("FAIL const_result: raw=%b unst=%b resp=%b, required 1101 0000 1", oraw, ounst, oresp);
        end
        handshake();
    endtask

    task automatic test_unstable();
        logic [4:0] seq;
        seq = 5'b10101;
        fv = {3'b000, seq[0]};
        force dut.chain_resp = fv;
        accept(64'hfeed_beef_0000_1111);
        for (int k = 0; k < 5; k++) begin
            repeat (16) @(posedge clk);
            #1;
            if (k < 4) begin
                fv = {3'b000, seq[k+1]};
                force dut.chain_resp = fv;
            end
            repeat (16) @(posedge clk);
        end
        #1;
        nvec++;
        if (ovalid !== 1'b1) begin
            nerr++;
            $display("FAIL unstable_latency: ovalid=%b at E0+160, required 1", ovalid);
        end
        nvec++;
        if (oraw !== 4'b0001 || ounst !== 4'b0001 || oresp !== 1'b1) begin
            nerr++;
            $display("FAIL unstable_result: raw=%b unst=%b resp=%b, required 0001 0001 1", oraw, ounst, oresp);
        end
    endtask

    task automatic test_hold_and_back_to_back();
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            ivalid = 1'b1;
            chal   = {32'hdead_0000, 32'(c)};
            @(posedge clk);
            #1;
            if (ovalid !== 1'b1 || oraw !== 4'b0001 || ounst !== 4'b0001 || oresp !== 1'b1 ||
                oready !== 1'b0 || dut.pulse !== 1'b0)
                ok = 1'b0;
        end
        ivalid = 1'b0;
        nvec++;
        if (ok !== 1'b1) begin
            nerr++;
            $display("FAIL hold_stable: outputs changed or input accepted while waiting, got ok=%b required 1", ok);
        end
        @(negedge clk);
        iready = 1'b1;
        @(posedge clk);
        #1;
        iready = 1'b0;
        nvec++;
        if (ovalid !== 1'b0 || oready !== 1'b1) begin
            nerr++;
            $display("FAIL hold_release: ovalid=%b oready=%b, required 0 1", ovalid, oready);
        end
        chal   = 64'h5555_aaaa_5555_aaaa;
        ivalid = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        nvec++;
        if (dut.pulse !== 1'b1 || oready !== 1'b0) begin
            nerr++;
            $display("FAIL next_accept: pulse=%b oready=%b, required 1 0", dut.pulse, oready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (69) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if ({dut.pulse, ovalid, oresp, oraw, ounst, oready} !== 12'd0) begin
            nerr++;
            $display("FAIL reset_mid: got %b, required all 0", {dut.pulse, ovalid, oresp, oraw, ounst, oready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if (oready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_mid_release: oready=%b, required 1", oready);
        end
        fv = 4'b0110;
        force dut.chain_resp = fv;
        accept(64'h0f0f_0f0f_1234_5678);
        wait_valid(n);
        nvec++;
        if (n !== 160 || oraw !== 4'b0110 || ounst !== 4'b0000 || oresp !== 1'b0) begin
            nerr++;
            $display("FAIL reset_fresh: n=%0d raw=%b unst=%b resp=%b, required 160 0110 0000 0", n, oraw, ounst, oresp);
        end
        handshake();
    endtask

    task automatic test_challenge_change();
        int n;
        fv = 4'b1111;
        force dut.chain_resp = fv;
        accept(64'hAAAA_0000_BBBB_1111);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chal   = 64'h1234_1234_1234_1234;
        ivalid = 1'b1;
        wait_valid(n);
        ivalid = 1'b0;
        nvec++;
        if (dut.chal !== 64'hAAAA_0000_BBBB_1111) begin
            nerr++;
            $display("FAIL chal_stable: captured %h, required aaaa0000bbbb1111", dut.chal);
        end
        nvec++;
        if (n !== 120 || oraw !== 4'b1111 || oresp !== 1'b0 || ounst !== 4'b0000) begin
            nerr++;
            $display("FAIL chal_result: n=%0d raw=%b resp=%b unst=%b, required 120 1111 0 0000", n, oraw, oresp, ounst);
        end
        handshake();
    endtask

    task automatic test_small();
        int n;
        logic [0:0] sv;
        for (int t = 0; t < 2; t++) begin
            sv = (t == 0) ? 1'b1 : 1'b0;
            force dut_s.chain_resp = sv;
            @(negedge clk);
            s_chal   = 64'h0000_0000_0000_00ff;
            s_ivalid = 1'b1;
            @(posedge clk);
            #1;
            s_ivalid = 1'b0;
            n = 0;
            while (!s_ovalid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            nvec++;
            if (n !== 6) begin
                nerr++;
                $display("FAIL small_latency: ovalid after %0d cycles, required 6", n);
            end
            nvec++;
            if (s_oraw !== sv || s_oresp !== sv[0] || s_ounst !== 1'b0) begin
                nerr++;
                $display("FAIL small_result: raw=%b resp=%b unst=%b, required %b %b 0", s_oraw, s_oresp, s_ounst, sv, sv[0]);
            end
            @(negedge clk);
            s_iready = 1'b1;
            @(posedge clk);
            #1;
            s_iready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_unstable();
        test_hold_and_back_to_back();
        test_reset_mid();
        test_challenge_change();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
